// File: rtl/scalar_wb_pkg.sv
// Shared constants and types for the scalar register-file writeback arbiter.
// The top module's optional scoreboard is enabled by SCALAR_WB_SCOREBOARD_EN.
package scalar_wb_pkg;

  localparam int XLEN     = 32;
  localparam int NPORT    = 3;
  localparam int RF_DEPTH = 32;
  localparam int RDW      = 5;

  typedef struct packed {
    logic [RDW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic            we;
    logic [RDW-1:0]  addr;
    logic [XLEN-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/scalar_wb_arbiter_select.sv
// Combinational round-robin picker: scans eligible requesters from ptr_i, skips
// destinations already granted in this scan and hands out up to NPORT grants.
module wb_rr_select
  import scalar_wb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0]            elig_i,
  input  logic [NREQ*RDW-1:0]        rd_i,
  input  logic [PW-1:0]              ptr_i,
  output logic [NREQ-1:0]            grant_o,
  output logic [NPORT-1:0]           port_vld_o,
  output logic [NPORT-1:0][PW-1:0]   port_idx_o,
  output logic [PW-1:0]              ptr_next_o
);

  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  logic [RDW-1:0]              rdArr [NREQ];
  logic [NPORT-1:0][RDW-1:0]   takenRd;
  logic [1:0]                  cnt;
  logic [PW:0]                 sum;
  logic [PW-1:0]               idx;
  logic                        clash;

  for (genvar i = 0; i < NREQ; i++) begin : g_rd
    assign rdArr[i] = rd_i[i*RDW +: RDW];
  end

  // Grants fill ports in scan order; ptr_next follows the last granted index.
  always_comb begin
    grant_o    = '0;
    port_vld_o = '0;
    port_idx_o = '0;
    ptr_next_o = ptr_i;
    takenRd    = '0;
    cnt        = '0;
    sum        = '0;
    idx        = '0;
    clash      = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(s);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx   = sum[PW-1:0];
      clash = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        if (2'(k) < cnt && takenRd[k] == rdArr[idx]) clash = 1'b1;
      end
      if (elig_i[idx] && cnt < 2'(NPORT) && !clash) begin
        grant_o[idx]    = 1'b1;
        port_vld_o[cnt] = 1'b1;
        port_idx_o[cnt] = idx;
        takenRd[cnt]    = rdArr[idx];
        cnt             = cnt + 2'd1;
        ptr_next_o      = (idx == LAST) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter for the 5R/3W scalar register file: round-robin grants, registered
// write ports and, with SCALAR_WB_SCOREBOARD_EN defined, a pending-write scoreboard.
module scalar_wb_arbiter #(
  parameter int NREQ = 4,
  parameter int XLEN = scalar_wb_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we0,
  output logic                 we1,
  output logic                 we2,
  output logic [4:0]           waddr0,
  output logic [4:0]           waddr1,
  output logic [4:0]           waddr2,
  output logic [XLEN-1:0]      wdata0,
  output logic [XLEN-1:0]      wdata1,
  output logic [XLEN-1:0]      wdata2,
  input  logic                 sb_set_valid,
  input  logic [4:0]           sb_set_rd,
  input  logic                 sb_flush,
  output logic [31:0]          sb_busy
);
  import scalar_wb_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [RDW-1:0]             rdArr   [NREQ];
  logic [XLEN-1:0]            dataArr [NREQ];
  logic [NREQ-1:0]            rdZero, elig, grant;
  logic [NPORT-1:0]           portVld;
  logic [NPORT-1:0][PW-1:0]   portIdx;
  logic [PW-1:0]              rrPtr_q, rrPtr_d;
  logic [NPORT-1:0]           we_q, we_d;
  logic [NPORT-1:0][RDW-1:0]  waddr_q, waddr_d;
  logic [NPORT-1:0][XLEN-1:0] wdata_q, wdata_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign rdArr[i]   = req_rd[i*RDW +: RDW];
    assign dataArr[i] = req_data[i*XLEN +: XLEN];
    assign rdZero[i]  = (rdArr[i] == '0);
  end

  // x0 writes are accepted immediately and simply dropped.
  assign elig      = req_valid & ~rdZero;
  assign req_ready = grant | (req_valid & rdZero);

  wb_rr_select #(.NREQ(NREQ), .PW(PW)) uSelect (
    .elig_i     (elig),
    .rd_i       (req_rd),
    .ptr_i      (rrPtr_q),
    .grant_o    (grant),
    .port_vld_o (portVld),
    .port_idx_o (portIdx),
    .ptr_next_o (rrPtr_d)
  );

  always_comb begin
    we_d    = portVld;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    for (int k = 0; k < NPORT; k++) begin
      if (portVld[k]) begin
        waddr_d[k] = rdArr[portIdx[k]];
        wdata_d[k] = dataArr[portIdx[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr_q <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we0    = we_q[0];
  assign we1    = we_q[1];
  assign we2    = we_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wdata0 = wdata_q[0];
  assign wdata1 = wdata_q[1];
  assign wdata2 = wdata_q[2];

`ifdef SCALAR_WB_SCOREBOARD_EN
  logic [RF_DEPTH-1:0] busy_q, busy_d;

  // Clears come from the committing port stage; a same-cycle set wins, flush beats all.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NPORT; k++) begin
      if (we_q[k]) busy_d[waddr_q[k]] = 1'b0;
    end
    if (sb_set_valid && sb_set_rd != '0) busy_d[sb_set_rd] = 1'b1;
    if (sb_flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign sb_busy = busy_q;
`else
  logic unusedSb;
  assign unusedSb = ^{sb_set_valid, sb_set_rd, sb_flush};
  assign sb_busy  = '0;
`endif

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Self-checking bench for scalar_wb_arbiter: directed vector table, hand sequences
// and a randomized run against a queue-based reference arbiter.
module tb_scalar_wb_arbiter;
  localparam int NREQ = 4;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 we0, we1, we2;
  logic [4:0]           waddr0, waddr1, waddr2;
  logic [XLEN-1:0]      wdata0, wdata1, wdata2;
  logic                 sb_set_valid;
  logic [4:0]           sb_set_rd;
  logic                 sb_flush;
  logic [31:0]          sb_busy;

  logic [4:0]      rdv   [NREQ];
  logic [XLEN-1:0] datav [NREQ];
  logic            weArr [3];
  logic [4:0]      waArr [3];
  logic [XLEN-1:0] wdArr [3];

  int testsRun    = 0;
  int testsFailed = 0;

  scalar_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .we0(we0), .we1(we1), .we2(we2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .sb_set_valid(sb_set_valid), .sb_set_rd(sb_set_rd), .sb_flush(sb_flush), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*5 +: 5]      = rdv[i];
      req_data[i*XLEN +: XLEN] = datav[i];
    end
    weArr[0] = we0;    weArr[1] = we1;    weArr[2] = we2;
    waArr[0] = waddr0; waArr[1] = waddr1; waArr[2] = waddr2;
    wdArr[0] = wdata0; wdArr[1] = wdata1; wdArr[2] = wdata2;
  end

  typedef struct {
    logic [3:0] valid;
    logic [4:0] rd [4];
    logic [3:0] expReady;
    logic [2:0] expWe;
    int         expSrc [3];
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [4:0] rds [4]);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      rdv[i]   = rds[i];
      datav[i] = $urandom;
    end
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    req_valid    = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    sb_flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rdv[i]   = '0;
      datav[i] = '0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void setVec(input int t, input logic [3:0] v, input logic [4:0] r0, r1, r2, r3,
                                 input logic [3:0] rdy, input logic [2:0] we, input int s0, s1, s2);
    vecs[t].valid     = v;
    vecs[t].rd[0]     = r0; vecs[t].rd[1] = r1; vecs[t].rd[2] = r2; vecs[t].rd[3] = r3;
    vecs[t].expReady  = rdy;
    vecs[t].expWe     = we;
    vecs[t].expSrc[0] = s0; vecs[t].expSrc[1] = s1; vecs[t].expSrc[2] = s2;
  endfunction

  // Reference arbiter: walk the rotated requester order, keep a set of claimed destinations.
  function automatic void refArbiter(input logic [3:0] v, input logic [4:0] rds [4], input int ptr,
                                     output logic [3:0] rdy, output int src [3], output int n, output int nptr);
    int          order [$];
    logic [31:0] usedMask;
    rdy      = '0;
    n        = 0;
    nptr     = ptr;
    usedMask = '0;
    for (int k = 0; k < 3; k++) src[k] = 0;
    for (int s = 0; s < NREQ; s++) order.push_back((ptr + s) % NREQ);
    foreach (order[j]) begin
      int i = order[j];
      if (v[i]) begin
        if (rds[i] == 5'd0) rdy[i] = 1'b1;
        else if (n < 3 && !usedMask[rds[i]]) begin
          rdy[i]            = 1'b1;
          usedMask[rds[i]]  = 1'b1;
          src[n]            = i;
          n++;
          nptr = (i + 1) % NREQ;
        end
      end
    end
  endfunction

  logic [4:0] tmpRd [4];
  logic [XLEN-1:0] savedData [4];

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    sb_flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rdv[i]   = '0;
      datav[i] = '0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset we%0d", k), 64'(weArr[k]), 64'(0));
      checkOutput($sformatf("reset waddr%0d", k), 64'(waArr[k]), 64'(0));
      checkOutput($sformatf("reset wdata%0d", k), 64'(wdArr[k]), 64'(0));
    end
    checkOutput("reset sb_busy", 64'(sb_busy), 64'(0));
    checkOutput("reset ready", 64'(req_ready), 64'(0));

    setVec(0, 4'b1111, 5'd1, 5'd2, 5'd3, 5'd4,  4'b0111, 3'b111, 0, 1, 2);
    setVec(1, 4'b0011, 5'd5, 5'd5, 5'd0, 5'd0,  4'b0001, 3'b001, 0, 0, 0);
    setVec(2, 4'b0100, 5'd0, 5'd0, 5'd0, 5'd0,  4'b0100, 3'b000, 0, 0, 0);
    setVec(3, 4'b1111, 5'd6, 5'd6, 5'd6, 5'd6,  4'b0001, 3'b001, 0, 0, 0);
    setVec(4, 4'b1010, 5'd0, 5'd9, 5'd0, 5'd9,  4'b0010, 3'b001, 1, 0, 0);
    setVec(5, 4'b1111, 5'd0, 5'd3, 5'd0, 5'd7,  4'b1111, 3'b011, 1, 3, 0);
    setVec(6, 4'b0000, 5'd1, 5'd2, 5'd3, 5'd4,  4'b0000, 3'b000, 0, 0, 0);
    setVec(7, 4'b1110, 5'd0, 5'd8, 5'd9, 5'd10, 4'b1110, 3'b111, 1, 2, 3);
    setVec(8, 4'b1111, 5'd1, 5'd2, 5'd1, 5'd2,  4'b0011, 3'b011, 0, 1, 0);

    for (int t = 0; t < 9; t++) begin
      doReset();
      applyStimulus(vecs[t].valid, vecs[t].rd);
      #1;
      checkOutput($sformatf("vec%0d ready", t), 64'(req_ready), 64'(vecs[t].expReady));
      tick();
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("vec%0d we%0d", t, k), 64'(weArr[k]), 64'(vecs[t].expWe[k]));
        if (vecs[t].expWe[k]) begin
          checkOutput($sformatf("vec%0d waddr%0d", t, k), 64'(waArr[k]), 64'(vecs[t].rd[vecs[t].expSrc[k]]));
          checkOutput($sformatf("vec%0d wdata%0d", t, k), 64'(wdArr[k]), 64'(datav[vecs[t].expSrc[k]]));
        end
      end
    end

    // Pointer advance: after granting req0..2, req3 goes first.
    doReset();
    tmpRd = '{5'd1, 5'd2, 5'd3, 5'd4};
    applyStimulus(4'b1111, tmpRd);
    tick();
    checkOutput("rr first waddr2", 64'(waddr2), 64'(3));
    req_valid = 4'b1000;
    #1;
    checkOutput("rr ptr3 ready", 64'(req_ready), 64'(4'b1000));
    tick();
    checkOutput("rr ptr3 we", 64'({we2, we1, we0}), 64'(3'b001));
    checkOutput("rr ptr3 waddr0", 64'(waddr0), 64'(4));
    checkOutput("rr ptr3 wdata0", 64'(wdata0), 64'(datav[3]));
    checkOutput("rr hold waddr1", 64'(waddr1), 64'(2));
    checkOutput("rr hold wdata1", 64'(wdata1), 64'(datav[1]));
    req_valid = 4'b1111;
    #1;
    checkOutput("rr wrap ready", 64'(req_ready), 64'(4'b0111));

    // Same-destination conflict resolved over two cycles.
    doReset();
    tmpRd = '{5'd5, 5'd5, 5'd0, 5'd0};
    applyStimulus(4'b0011, tmpRd);
    #1;
    checkOutput("conflict ready1", 64'(req_ready), 64'(4'b0001));
    tick();
    checkOutput("conflict c1 waddr0", 64'(waddr0), 64'(5));
    checkOutput("conflict c1 wdata0", 64'(wdata0), 64'(datav[0]));
    req_valid = 4'b0010;
    #1;
    checkOutput("conflict ready2", 64'(req_ready), 64'(4'b0010));
    tick();
    checkOutput("conflict c2 we0", 64'(we0), 64'(1));
    checkOutput("conflict c2 waddr0", 64'(waddr0), 64'(5));
    checkOutput("conflict c2 wdata0", 64'(wdata0), 64'(datav[1]));

    // Asynchronous reset drops a registered write before it commits.
    doReset();
    tmpRd = '{5'd11, 5'd12, 5'd13, 5'd0};
    applyStimulus(4'b0111, tmpRd);
    tick();
    checkOutput("midreset pre we", 64'({we2, we1, we0}), 64'(3'b111));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset we", 64'({we2, we1, we0}), 64'(0));
    checkOutput("midreset waddr", 64'({waddr2, waddr1, waddr0}), 64'(0));
    checkOutput("midreset wdata0", 64'(wdata0), 64'(0));

`ifdef SCALAR_WB_SCOREBOARD_EN
    doReset();
    sb_set_valid = 1'b1; sb_set_rd = 5'd7;
    tick();
    sb_set_valid = 1'b0;
    checkOutput("sb set7", 64'(sb_busy), 64'(32'h80));
    tmpRd = '{5'd7, 5'd0, 5'd0, 5'd0};
    applyStimulus(4'b0001, tmpRd);
    tick();
    req_valid = '0;
    checkOutput("sb busy N+1", 64'(sb_busy), 64'(32'h80));
    checkOutput("sb we N+1", 64'(we0), 64'(1));
    tick();
    checkOutput("sb clear N+2", 64'(sb_busy), 64'(0));
    applyStimulus(4'b0001, tmpRd);
    tick();
    req_valid    = '0;
    sb_set_valid = 1'b1; sb_set_rd = 5'd7;
    tick();
    checkOutput("sb set wins", 64'(sb_busy), 64'(32'h80));
    for (int r = 4; r < 7; r++) begin
      sb_set_rd = 5'(r);
      tick();
    end
    sb_set_valid = 1'b0;
    checkOutput("sb mask F0", 64'(sb_busy), 64'(32'hF0));
    sb_flush = 1'b1; sb_set_valid = 1'b1; sb_set_rd = 5'd9;
    tick();
    sb_flush = 1'b0; sb_set_valid = 1'b0;
    checkOutput("sb flush", 64'(sb_busy), 64'(0));
`else
    doReset();
    sb_set_valid = 1'b1; sb_set_rd = 5'd7;
    tick();
    sb_set_valid = 1'b0;
    checkOutput("sb disabled", 64'(sb_busy), 64'(0));
`endif

    // Randomized run against the reference arbiter.
    begin
      logic            active [NREQ];
      logic            distinctTx [NREQ];
      int              waitCnt [NREQ];
      logic [3:0]      accepted, rdy;
      int              src [3];
      int              n, nptr, modelPtr;
      logic            expWe [3];
      logic [4:0]      expWa [3];
      logic [XLEN-1:0] expWd [3];
      logic            clash;
      doReset();
      modelPtr = 0;
      accepted = '0;
      for (int i = 0; i < NREQ; i++) begin
        active[i] = 1'b0; distinctTx[i] = 1'b0; waitCnt[i] = 0;
      end
      for (int k = 0; k < 3; k++) begin
        expWe[k] = 1'b0; expWa[k] = '0; expWd[k] = '0;
      end
      for (int c = 0; c < 10000; c++) begin
        for (int k = 0; k < 3; k++) begin
          checkOutput($sformatf("stress c%0d port%0d", c, k),
                      64'({weArr[k], waArr[k], wdArr[k]}), 64'({expWe[k], expWa[k], expWd[k]}));
        end
        clash = (we0 && we1 && waddr0 == waddr1) || (we0 && we2 && waddr0 == waddr2) ||
                (we1 && we2 && waddr1 == waddr2);
        checkOutput($sformatf("stress c%0d distinct", c), 64'(clash), 64'(0));
        for (int i = 0; i < NREQ; i++) begin
          if (active[i] && accepted[i]) active[i] = 1'b0;
          if (!active[i] && $urandom_range(0, 99) < 70) begin
            active[i]     = 1'b1;
            distinctTx[i] = (c >= 5000);
            waitCnt[i]    = 0;
            rdv[i]        = (c >= 5000) ? 5'(4 * $urandom_range(0, 6) + i + 1) : 5'($urandom_range(0, 7));
            datav[i]      = $urandom;
          end
          req_valid[i] = active[i];
        end
        #1;
        for (int i = 0; i < NREQ; i++) tmpRd[i] = rdv[i];
        refArbiter(req_valid, tmpRd, modelPtr, rdy, src, n, nptr);
        checkOutput($sformatf("stress c%0d ready", c), 64'(req_ready), 64'(rdy));
        for (int k = 0; k < 3; k++) begin
          expWe[k] = (k < n);
          if (k < n) begin
            expWa[k] = rdv[src[k]];
            expWd[k] = datav[src[k]];
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (active[i]) begin
            if (rdy[i]) begin
              if (distinctTx[i]) checkOutput($sformatf("stress c%0d wait%0d", c, i), 64'(waitCnt[i] <= NREQ), 64'(1));
            end else begin
              waitCnt[i]++;
            end
          end
        end
        accepted = rdy;
        modelPtr = nptr;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/scalar_wb_arbiter.md
# scalar_wb_arbiter

Writeback arbiter and scheduler for the 5R/3W scalar register file in the compute unit. It accepts writeback requests from NREQ functional-unit sources (ALU, MUL/DIV, LSU, CSR/atomic) over valid/ready handshakes. Each cycle it grants at most three of them with round-robin fairness and resolves same-destination conflicts. The granted writes drive the register file's three write ports through a one-cycle registered stage. An optional pending-write scoreboard tracks in-flight destinations for issue hazard checks.

## Interface
- NREQ, 4, number of writeback requesters; legal range 3..8
- XLEN, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  NREQ  request i holds a write
- req_rd  in  NREQ*5  destination of request i, slice [5i+4:5i]
- req_data  in  NREQ*XLEN  write data of request i
- req_ready  out  NREQ  request i accepted this cycle (combinational)
- we0/we1/we2  out  1  register-file write enables (registered)
- waddr0/waddr1/waddr2  out  5  write addresses (registered)
- wdata0/wdata1/wdata2  out  XLEN  write data (registered)
- sb_set_valid  in  1  issue stage marks a destination pending
- sb_set_rd  in  5  destination being marked
- sb_flush  in  1  clears all pending bits
- sb_busy  out  32  pending-write mask; bit 0 is always 0

## Operation
- A transfer on request i happens when req_valid[i] && req_ready[i]. A requester holds valid, rd and data stable until the transfer.
- Requests with rd==0 get req_ready=1 whenever valid. They use no port and produce no write.
- Eligible request: valid, rd!=0.
- Arbitration scans the eligible requests in index order starting at rr_ptr and wrapping modulo NREQ.
  - A request is skipped if its rd matches an rd already granted in this scan.
  - Scanning stops after 3 grants.
- The k-th grant in scan order (k=0,1,2) is assigned to port k.
- rr_ptr update:
  - After a cycle with ≥1 port grant, rr_ptr ← (index of last granted request + 1) mod NREQ.
  - Otherwise rr_ptr is unchanged.
- Port outputs are registered each cycle:
  - weK ← 1 if port K was granted, else 0.
  - waddrK and wdataK load the granted rd and data; they hold their previous value when weK=0.
- Because granted rds are always distinct, the register file's internal port priority never matters.
- Scoreboard (only with the macro, see Configuration):
  - sb_set_valid with sb_set_rd!=0 sets busy[sb_set_rd].
  - Each registered weK=1 clears busy[waddrK] at that same edge, i.e. the edge at which the register file commits.
  - Set and clear of the same bit in one cycle: set wins.
  - sb_flush clears all bits and has priority over a same-cycle set.
  - sb_flush does not cancel port writes already registered.

## Timing
- Reset values: we0..2=0, waddr0..2=0, wdata0..2=0, rr_ptr=0, sb_busy=0. req_ready follows its combinational definition.
- Grant in cycle N → weK=1 during N+1 → register file updated at the end of N+1. sb_busy is clear and the read data is correct from N+2.
- req_ready is combinational from req_valid, req_rd and rr_ptr; there is no dependency from ready back to valid.
- Throughput: 3 writes per cycle sustained. A single requester can complete one transfer per cycle.
- Reset asserted mid-operation drops any registered write not yet committed, and all state returns to reset values.

## Configuration
- SCALAR_WB_SCOREBOARD_EN defined: the pending-write scoreboard is built as described.
- Not defined: sb_busy is tied to 0, and sb_set_valid, sb_set_rd and sb_flush are ignored. Arbitration and port behaviour are identical.

## Structure
- Package scalar_wb_pkg holds:
  - XLEN, NPORT=3, RF_DEPTH=32
  - typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - typedef wb_port_t {logic we; logic [4:0] addr; logic [XLEN-1:0] data;}
- Sub-module wb_rr_select is the combinational picker. Inputs: eligible mask, rd vector, rr_ptr. Outputs: grant mask, port-to-requester index per port, next rr_ptr. The top level holds the registers and the scoreboard.

## Test plan
- Reset, then all 4 requesters valid with rd 1,2,3,4 → req_ready=0111. Next cycle we0..2=1 with waddr 1,2,3; rr_ptr=3; the following cycle grants req3.
- req0 rd=5 and req1 rd=5 valid together, rr_ptr=0 → only req0 ready; req1 is granted the next cycle; waddr0=5 on both cycles with the correct data.
- req2 valid with rd=0 and no others → req_ready[2]=1; we0..2 stay 0.
- Scoreboard: sb_set rd=7; a request rd=7 is granted in cycle N → sb_busy[7]=1 through N+1 and 0 at N+2. A sb_set of rd=7 in the same cycle as we=1 for rd 7 → busy[7] stays 1.
- Assert sb_flush with busy=0x0000_00F0 → 0 next cycle. Assert rst_n low while weK=1 → outputs go to 0 immediately and no write commits.
- Random stress, 10k cycles: every accepted nonzero-rd request appears exactly once on a port. No two ports ever share an address in a cycle. No valid request waits more than NREQ cycles when all rds are distinct.
